seg7_scan_ctrl: RTL and testbench

Parametrised, bus-mapped 7-segment display controller that replaces the hard-wired digit peripheral behind `Bridge`. It holds a hex data register and a control register written by the CPU through the bridge's byte-enable write port. It time-multiplexes `NUM_DIGITS` digits with a programmable scan rate, and adds per-digit enable, decimal-point mask, global blank and blink modes. Its outputs drive `dig_en` and the shared segment lines (`DN_*0`, mirrored to `DN_*1` at SoC top).

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_hex_decoder.sv | 17 +
 rtl/seg7_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan controller:
//   - register selector (addr[2]): DATA / CTRL
//   - CTRL field bit positions
//   - active-low hex segment patterns {G,F,E,D,C,B,A}
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {
        REG_DATA = 1'b0,
        REG_CTRL = 1'b1
    } reg_sel_e;

    // CTRL register layout
    localparam int CTRL_EN_LSB    = 0;   // [7:0]  digit enable mask
    localparam int CTRL_DP_LSB    = 8;   // [15:8] decimal-point mask
    localparam int CTRL_BLANK_BIT = 16;  // blank all digits
    localparam int CTRL_BLINK_BIT = 17;  // blink enable

    // Active-low segment patterns for nibbles 0..F, bit order {G,F,E,D,C,B,A}
    localparam logic [6:0] HEX_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage : seg7_pkg

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
// Combinational nibble to active-low 7-segment pattern.
// Ports:
//   nibble_i  [3:0]  hex digit value
//   seg_n_o   [6:0]  active-low segments {G,F,E,D,C,B,A}
// -----------------------------------------------------------------------------
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = HEX_PATTERNS[nibble_i];

endmodule : seg7_hex_decoder

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Bus-mapped, time-multiplexed 7-segment display controller.
// Holds a DATA register (one nibble per digit) and a CTRL register (enable
// mask, DP mask, blank-all, blink enable), scans NUM_DIGITS digits at
// SCAN_DIV clocks per slot and blinks every BLINK_FRAMES full frames.
// Ports:
//   cpu_clk          clock, all state on rising edge
//   cpu_rst          asynchronous active-high reset
//   addr   [11:0]    byte address, bit 2 selects DATA(0) / CTRL(1)
//   we     [3:0]     byte write enables, any nonzero value is a write
//   wdata  [31:0]    write data
//   rdata  [31:0]    combinational readback of the selected register
//   dig_en [N-1:0]   active-low digit selects (one-hot-low or all high)
//   seg    [7:0]     active-low {DP,G,F,E,D,C,B,A}
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
)
(
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [11:0]           addr,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [7:0]            seg
);

    localparam int DATA_W  = 4 * NUM_DIGITS;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    // Register file
    logic [NUM_DIGITS-1:0][3:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]      en_q, en_d;
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
    logic                       blank_q, blank_d;
    logic                       blink_q, blink_d;

    // Scan / blink timing
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic               scan_tick, idx_wrap, frame_wrap;

    // Registered outputs
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic [7:0]            seg_q, seg_d;

    // Bus side
    reg_sel_e    reg_sel;
    logic        wr_en;
    logic [31:0] data_rd, ctrl_rd, data_wr, ctrl_wr;
    logic [6:0]  hex_n;
    logic        dark;

    assign reg_sel = reg_sel_e'(addr[2]);
    assign wr_en   = |we;

    // 32-bit register images; unimplemented bits read as zero
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        data_rd = 32'(data_q);
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN_LSB +: NUM_DIGITS] = en_q;
        ctrl_rd[CTRL_DP_LSB +: NUM_DIGITS] = dp_q;
        ctrl_rd[CTRL_BLANK_BIT]            = blank_q;
        ctrl_rd[CTRL_BLINK_BIT]            = blink_q;
    end

    assign rdata = (reg_sel == REG_CTRL) ? ctrl_rd : data_rd;

    // Byte-enable merge onto the current image, then extract stored fields
    always_comb begin
        data_wr = data_rd;
        ctrl_wr = ctrl_rd;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                data_wr[8*i +: 8] = wdata[8*i +: 8];
                ctrl_wr[8*i +: 8] = wdata[8*i +: 8];
            end
        end

        data_d  = data_q;
        en_d    = en_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        blink_d = blink_q;
        if (wr_en && reg_sel == REG_DATA) begin
            data_d = data_wr[DATA_W-1:0];
        end
        if (wr_en && reg_sel == REG_CTRL) begin
            en_d    = ctrl_wr[CTRL_EN_LSB +: NUM_DIGITS];
            dp_d    = ctrl_wr[CTRL_DP_LSB +: NUM_DIGITS];
            blank_d = ctrl_wr[CTRL_BLANK_BIT];
            blink_d = ctrl_wr[CTRL_BLINK_BIT];
        end
    end

    // Slot, frame and blink-phase counters
    always_comb begin
        scan_tick  = (scan_cnt_q == SCAN_LAST);
        idx_wrap   = scan_tick && (idx_q == IDX_LAST);
        frame_wrap = idx_wrap && (frame_cnt_q == FRAME_LAST);

        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);

        idx_d = idx_q;
        if (scan_tick) begin
            idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
        end

        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (idx_wrap) begin
            frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + FRAME_W'(1);
            if (frame_wrap) begin
                blink_ph_d = ~blink_ph_q;
            end
        end

        // Turning blink off restarts the blink timing; this wins over a
        // frame wrap on the same edge.
        if (blink_q && !blink_d) begin
            frame_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end
    end

    seg7_hex_decoder u_hex_decoder (
        .nibble_i (data_q[idx_q]),
        .seg_n_o  (hex_n)
    );

    // Dark slots still occupy their time so brightness stays uniform
    always_comb begin
        dark     = !en_q[idx_q] || blank_q || (blink_q && blink_ph_q);
        dig_en_d = '1;
        seg_d    = 8'hFF;
        if (!dark) begin
            dig_en_d[idx_q] = 1'b0;
            seg_d           = {~dp_q[idx_q], hex_n};
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            data_q      <= '0;
            en_q        <= '1;
            dp_q        <= '0;
            blank_q     <= 1'b0;
            blink_q     <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            dig_en_q    <= '1;
            seg_q       <= 8'hFF;
        end else begin
            data_q      <= data_d;
            en_q        <= en_d;
            dp_q        <= dp_d;
            blank_q     <= blank_d;
            blink_q     <= blink_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            blink_ph_q  <= blink_ph_d;
            dig_en_q    <= dig_en_d;
            seg_q       <= seg_d;
        end
    end

    assign dig_en = dig_en_q;
    assign seg    = seg_q;

    // Address bits other than [2] and CTRL bits above blink are don't-care
    logic unused_bits;
    assign unused_bits = ^{addr[11:3], addr[1:0], ctrl_wr[31:18]};

endmodule : seg7_scan_ctrl

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Scoreboard bench. The main instance (8 digits, 4 clocks/slot, blink every
// 2 frames) is predicted by a reference model that derives the digit slot
// and blink phase arithmetically from the number of clock edges since reset;
// the expected response for each edge is queued and a monitor compares it on
// the falling edge. A second instance (4 digits) covers the narrow register
// width, the wrap after digit 3 and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF;
    localparam logic [31:0] CTRL_MASK = 32'h0003_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr = '0;
    logic [3:0]  we = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    logic        b_rst = 1'b1;
    logic [11:0] b_addr = '0;
    logic [3:0]  b_we = '0;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_rdata;
    logic [3:0]  b_dig_en;
    logic [7:0]  b_seg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .dig_en  (dig_en),
        .seg     (seg)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(2), .BLINK_FRAMES(1)) dut_b (
        .cpu_clk (clk),
        .cpu_rst (b_rst),
        .addr    (b_addr),
        .we      (b_we),
        .wdata   (b_wdata),
        .rdata   (b_rdata),
        .dig_en  (b_dig_en),
        .seg     (b_seg)
    );

    // Display patterns with DP off, straight from the segment table
    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {dig_en, seg} given register images d/c and the state after
    // n edges since reset, with the blink timing restarted at edge tc.
    function automatic logic [15:0] model_out(input logic [31:0] d, input logic [31:0] c,
                                              input int n, input int tc,
                                              input int nd, input int sd, input int bf);
        int         idx, frames, ph;
        logic [7:0] dg, sg;
        idx    = (n / sd) % nd;
        frames = (n / (sd * nd)) - (tc / (sd * nd));
        ph     = (frames / bf) % 2;
        if (!c[idx] || c[16] || (c[17] && ph == 1)) begin
            return 16'hFFFF;
        end
        dg      = 8'hFF;
        dg[idx] = 1'b0;
        sg      = hex_tab[(d >> (4 * idx)) & 32'hF];
        sg[7]   = ~c[8 + idx];
        return {dg, sg};
    endfunction

    typedef struct {
        logic [7:0]  dig_en;
        logic [7:0]  seg;
        logic [31:0] data_img;
        logic [31:0] ctrl_img;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (main instance)
    logic [31:0] m_data = '0;
    logic [31:0] m_ctrl = 32'h0000_00FF;
    int          m_t  = 0;
    int          m_tc = 0;
    logic [31:0] m_img;
    logic [15:0] m_o;
    logic        m_old_blink;
    exp_t        m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data = '0;
            m_ctrl = 32'h0000_00FF;
            m_t    = 0;
            m_tc   = 0;
            sb_q.delete();
        end else begin
            // outputs after this edge reflect the state before it
            m_o = model_out(m_data, m_ctrl, m_t, m_tc, ND, SD, BF);
            if (we != 4'b0000) begin
                m_img = addr[2] ? m_ctrl : m_data;
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) m_img[8*i +: 8] = wdata[8*i +: 8];
                end
                if (addr[2]) begin
                    m_old_blink = m_ctrl[17];
                    m_ctrl = m_img & CTRL_MASK;
                    if (m_old_blink && !m_ctrl[17]) m_tc = m_t + 1;
                end else begin
                    m_data = m_img & DATA_MASK;
                end
            end
            m_t++;
            m_e.dig_en   = m_o[15:8];
            m_e.seg      = m_o[7:0];
            m_e.data_img = m_data;
            m_e.ctrl_img = m_ctrl;
            sb_q.push_back(m_e);
        end
    end

    // Monitor: compares on the falling edge, away from the active edge
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            check("reset_dig_en", 32'(dig_en), 32'h0000_00FF);
            check("reset_seg", 32'(seg), 32'h0000_00FF);
        end else if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("dig_en", 32'(dig_en), 32'(mon_e.dig_en));
            check("seg", 32'(seg), 32'(mon_e.seg));
            check("rdata", rdata, addr[2] ? mon_e.ctrl_img : mon_e.data_img);
        end
    end

    task automatic write(input logic [11:0] a, input logic [3:0] w, input logic [31:0] d);
        addr  = a;
        we    = w;
        wdata = d;
        @(posedge clk); #1;
        we = 4'b0000;
    endtask

    task automatic idle(input int n);
        we = 4'b0000;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [31:0] r_d;
    logic [11:0] r_a;
    logic [15:0] b_o;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_dig_en_direct", 32'(dig_en), 32'h0000_00FF);
        check("rst_seg_direct", 32'(seg), 32'h0000_00FF);
        addr = 12'h000; #1;
        check("rst_data_read", rdata, 32'h0000_0000);
        addr = 12'h004; #1;
        check("rst_ctrl_read", rdata, 32'h0000_00FF);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- full scan ----------------
        write(12'h000, 4'hF, 32'h1234_5678);
        idle(40);

        // ---------------- byte enables ----------------
        write(12'h000, 4'b0010, 32'hAABB_CCDD);
        addr = 12'h000; #1;
        check("byte_enable_read", rdata, 32'h1234_CC78);
        idle(8);

        // ---------------- masks ----------------
        write(12'h004, 4'hF, 32'h0000_010F);
        idle(40);
        write(12'h004, 4'hF, 32'h0001_00FF);  // blank-all
        idle(12);

        // ---------------- blink, then clear ----------------
        write(12'h004, 4'hF, 32'h0002_00FF);
        idle(300);
        write(12'h004, 4'hF, 32'h0000_00FF);
        idle(40);
        write(12'h004, 4'hF, 32'h0002_AAFF);
        idle(90);
        write(12'h004, 4'b0100, 32'h0000_0000);  // clears blink via byte 2 only
        idle(20);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                r_a = 12'($urandom);
                r_d = $urandom;
                if (r_a[2] && $urandom_range(7) != 0) r_d[16] = 1'b0;
                addr  = r_a;
                we    = 4'($urandom_range(15, 1));
                wdata = r_d;
            end else begin
                we   = 4'b0000;
                addr = 12'($urandom);
            end
            @(posedge clk); #1;
        end
        we = 4'b0000;
        idle(5);

        // ---------------- async reset mid-slot ----------------
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midslot_rst_dig_en", 32'(dig_en), 32'h0000_00FF);
        check("midslot_rst_seg", 32'(seg), 32'h0000_00FF);
        @(posedge clk); #1;
        rst = 1'b0;
        write(12'h000, 4'hF, 32'h0FED_CBA9);
        idle(70);

        // ---------------- 4-digit instance ----------------
        @(posedge clk); #1;
        b_rst   = 1'b0;
        b_addr  = 12'h000;
        b_we    = 4'hF;
        b_wdata = 32'hFFFF_1234;
        @(posedge clk); #1;
        b_we = 4'b0000;
        check("b_data_read", b_rdata, 32'h0000_1234);
        b_addr = 12'h004; #1;
        check("b_ctrl_read", b_rdata, 32'h0000_000F);
        b_addr = 12'h000;
        for (int n = 2; n <= 17; n++) begin
            @(posedge clk); #2;
            b_o = model_out(32'h0000_1234, 32'h0000_000F, n - 1, 0, 4, 2, 1);
            check("b_dig_en", 32'(b_dig_en), 32'(b_o[11:8]));
            check("b_seg", 32'(b_seg), 32'(b_o[7:0]));
        end
        @(posedge clk); #3;
        b_rst = 1'b1;
        #1;
        check("b_async_rst_dig_en", 32'(b_dig_en), 32'h0000_000F);
        check("b_async_rst_seg", 32'(b_seg), 32'h0000_00FF);
        check("b_async_rst_data", b_rdata, 32'h0000_0000);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seg7_scan_ctrl
